// File: rtl/simplez_core.sv
// simplez_core: multicycle Simplez processor with an external single-cycle-latency
// synchronous RAM port, a memory-mapped LED register and resume-from-HALT.
// Every instruction runs F0 (present PC), F1 (latch RI, bump PC), D (decode and
// execute register-only ops); memory ops add O0 (present CD, write on ST) and
// O1 (consume read data). HALT parks the core in HALTED until cont is seen.
// There is no handshake: the RAM always answers one cycle after mem_addr is
// presented, so the core simply schedules its reads around that latency.
module simplez_core #(
    parameter int              DATAW     = 12,
    parameter int              ADDRW     = 9,
    parameter int              LEDW      = 4,
    parameter logic [ADDRW-1:0] LEDS_ADDR = 9'o100
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cont,
    output logic [ADDRW-1:0] mem_addr,
    output logic             mem_we,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata,
    output logic [LEDW-1:0]  leds,
    output logic             stop,
    output logic [ADDRW-1:0] pc,
    output logic [DATAW-1:0] ac,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_F0     = 3'd0,
        S_F1     = 3'd1,
        S_D      = 3'd2,
        S_O0     = 3'd3,
        S_O1     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [2:0] OP_ST   = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t           state_q;
    logic [ADDRW-1:0] pc_q;
    logic [DATAW-1:0] ac_q;
    logic [DATAW-1:0] ri_q;
    logic [LEDW-1:0]  leds_q;

    logic [2:0]       co;
    logic [ADDRW-1:0] cd;

    assign co = ri_q[DATAW-1 -: 3];
    assign cd = ri_q[ADDRW-1:0];

    // Address/write-enable decode: only O0 looks at the operand address,
    // every other state keeps PC on the bus.
    always_comb begin
        mem_addr = pc_q;
        mem_we   = 1'b0;
        if (state_q == S_O0) begin
            mem_addr = cd;
            mem_we   = (co == OP_ST);
        end
    end

    assign mem_wdata = ac_q;
    assign leds      = leds_q;
    assign stop      = (state_q == S_HALTED);
    assign pc        = pc_q;
    assign ac        = ac_q;
    assign state_dbg = state_q;

    // Sequencer and datapath registers; synchronous active-low reset wins over all states.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_F0;
            pc_q    <= '0;
            ac_q    <= '0;
            ri_q    <= '0;
            leds_q  <= '0;
        end else begin
            case (state_q)
                S_F0: begin
                    state_q <= S_F1;
                end
                S_F1: begin
                    ri_q    <= mem_rdata;
                    pc_q    <= pc_q + ADDRW'(1);
                    state_q <= S_D;
                end
                S_D: begin
                    state_q <= S_F0;
                    case (co)
                        OP_BR:   pc_q <= cd;
                        OP_BZ:   if (ac_q == '0) pc_q <= cd;
                        OP_CLR:  ac_q <= '0;
                        OP_DEC:  ac_q <= ac_q - DATAW'(1);
                        OP_HALT: state_q <= S_HALTED;
                        default: state_q <= S_O0;
                    endcase
                end
                S_O0: begin
                    // The RAM takes the store too; the LED port just snoops it.
                    if (co == OP_ST && cd == LEDS_ADDR) begin
                        leds_q <= ac_q[LEDW-1:0];
                    end
                    state_q <= S_O1;
                end
                S_O1: begin
                    if (co == OP_LD) begin
                        ac_q <= mem_rdata;
                    end else if (co == OP_ADD) begin
                        ac_q <= ac_q + mem_rdata;
                    end
                    state_q <= S_F0;
                end
                S_HALTED: begin
                    // PC already points past the HALT, so resuming is just a refetch.
                    if (cont) begin
                        state_q <= S_F0;
                    end
                end
                default: begin
                    state_q <= S_F0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simplez_core.sv
// Bench for simplez_core: an instruction-level Simplez interpreter turns each
// instruction into its expected per-cycle bus/register trace, and every cycle
// the DUT outputs are compared against the front of that trace.
module tb_simplez_core;

    localparam int DW = 12;
    localparam int AW = 9;
    localparam int LW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    logic cont;
    always #5 clk = ~clk;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [LW-1:0] leds;
    logic          stop;
    logic [AW-1:0] pc;
    logic [DW-1:0] ac;
    logic [2:0]    state_dbg;

    simplez_core dut (
        .clk       (clk),
        .rstn      (rstn),
        .cont      (cont),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .leds      (leds),
        .stop      (stop),
        .pc        (pc),
        .ac        (ac),
        .state_dbg (state_dbg)
    );

    // ---------------- synchronous RAM ----------------
    logic [DW-1:0] ram [0:511];
    logic          ld_en;
    logic [AW-1:0] ld_a;
    logic [DW-1:0] ld_d;

    always @(posedge clk) begin
        if (ld_en) ram[ld_a] <= ld_d;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        bit            addr_chk;
        bit            we;
        bit            stp;
        logic [AW-1:0] pcv;
        logic [DW-1:0] acv;
        logic [LW-1:0] ledv;
    } rec_t;

    rec_t exp_q[$];

    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ac;
    logic [LW-1:0] m_leds;
    bit            m_halted;
    logic [DW-1:0] m_mem [0:511];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input bit a_chk, input bit we, input bit st,
                        input logic [AW-1:0] p, input logic [DW-1:0] acc, input logic [LW-1:0] l);
        rec_t r;
        r.addr = a; r.addr_chk = a_chk; r.we = we; r.stp = st;
        r.pcv = p; r.acv = acc; r.ledv = l;
        exp_q.push_back(r);
    endtask

    function automatic logic [DW-1:0] ins(input logic [2:0] op, input logic [AW-1:0] cd);
        return {op, cd};
    endfunction

    // Execute one instruction at ISA level and queue the cycles it must take.
    task automatic model_instr();
        logic [DW-1:0] ir;
        logic [2:0]    op;
        logic [AW-1:0] cd;
        logic [AW-1:0] pc1;
        ir  = m_mem[m_pc];
        op  = ir[11:9];
        cd  = ir[8:0];
        pc1 = m_pc + 9'd1;
        push(m_pc, 1'b1, 1'b0, 1'b0, m_pc, m_ac, m_leds);  // fetch address out
        push(m_pc, 1'b0, 1'b0, 1'b0, m_pc, m_ac, m_leds);  // fetch data back
        push(pc1,  1'b1, 1'b0, 1'b0, pc1,  m_ac, m_leds);  // decode
        m_pc = pc1;
        case (op)
            3'd3: m_pc = cd;
            3'd4: if (m_ac == 12'd0) m_pc = cd;
            3'd5: m_ac = 12'd0;
            3'd6: m_ac = m_ac - 12'd1;
            3'd7: m_halted = 1'b1;
            default: begin
                push(cd, 1'b1, op == 3'd0, 1'b0, pc1, m_ac, m_leds);
                if (op == 3'd0) begin
                    m_mem[cd] = m_ac;
                    if (cd == 9'o100) m_leds = m_ac[3:0];
                end
                push(pc1, 1'b1, 1'b0, 1'b0, pc1, m_ac, m_leds);
                if (op == 3'd1) m_ac = m_mem[cd];
                else if (op == 3'd2) m_ac = m_ac + m_mem[cd];
            end
        endcase
    endtask

    task automatic model_reset();
        m_pc = '0; m_ac = '0; m_leds = '0; m_halted = 1'b0;
        exp_q.delete();
    endtask

    // Compare the current cycle's DUT outputs with the model; called at negedge.
    task automatic check_cycle();
        rec_t r;
        if (exp_q.size() == 0) begin
            if (m_halted) push(m_pc, 1'b1, 1'b0, 1'b1, m_pc, m_ac, m_leds);
            else model_instr();
        end
        r = exp_q.pop_front();
        if (r.addr_chk) chk("mem_addr", 32'(mem_addr), 32'(r.addr));
        chk("mem_we",    32'(mem_we),    32'(r.we));
        chk("stop",      32'(stop),      32'(r.stp));
        chk("pc",        32'(pc),        32'(r.pcv));
        chk("ac",        32'(ac),        32'(r.acv));
        chk("leds",      32'(leds),      32'(r.ledv));
        chk("mem_wdata", 32'(mem_wdata), 32'(r.acv));
        if (r.stp && cont) m_halted = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_a = a; ld_d = d;
        m_mem[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_cycles(input int n, input logic c);
        cont = c;
        repeat (n) begin
            check_cycle();
            @(negedge clk);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n_cyc;
        rstn = 1'b0; cont = 1'b0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
        for (int i = 0; i < 512; i++) m_mem[i] = 12'd0;
        model_reset();
        @(negedge clk);

        load(9'd0,   ins(3'd1, 9'd10));   // LD 10
        load(9'd1,   ins(3'd2, 9'd11));   // ADD 11
        load(9'd2,   ins(3'd0, 9'd12));   // ST 12
        load(9'd3,   ins(3'd7, 9'd0));    // HALT
        load(9'd4,   ins(3'd5, 9'd0));    // CLR
        load(9'd5,   ins(3'd4, 9'd20));   // BZ 20
        load(9'd10,  12'd5);
        load(9'd11,  12'd7);
        load(9'd20,  ins(3'd6, 9'd0));    // DEC
        load(9'd21,  ins(3'd4, 9'd30));   // BZ 30 (not taken)
        load(9'd22,  ins(3'd2, 9'd40));   // ADD 40
        load(9'd23,  ins(3'd1, 9'd41));   // LD 41
        load(9'd24,  ins(3'd0, 9'o100));  // ST LEDs
        load(9'd25,  ins(3'd3, 9'd511));  // BR 511
        load(9'd40,  12'd2);
        load(9'd41,  12'hABC);
        load(9'd511, ins(3'd5, 9'd0));    // CLR, then wrap to 0

        // reset state
        chk("rst0_pc", 32'(pc), 32'd0);
        chk("rst0_stop", 32'(stop), 32'd0);
        chk("rst0_we", 32'(mem_we), 32'd0);
        chk("rst0_addr", 32'(mem_addr), 32'd0);

        // start, then reset in the middle of the ADD
        rstn = 1'b1; model_reset();
        run_cycles(7, 1'b0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ac", 32'(ac), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_stop", 32'(stop), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);

        // LD/ADD/ST/HALT: stop after 18 cycles
        rstn = 1'b1; model_reset();
        n_cyc = 0;
        while (n_cyc < 40 && stop !== 1'b1) begin
            check_cycle();
            @(negedge clk);
            n_cyc++;
        end
        chk("halt_latency", 32'(n_cyc), 32'd18);
        chk("ram12", 32'(ram[12]), 32'd12);
        chk("model_mem12", 32'(m_mem[12]), 32'd12);
        chk("ac_after_add", 32'(ac), 32'd12);

        // stay halted, then resume with a one-cycle cont pulse
        run_cycles(10, 1'b0);
        chk("halted_pc", 32'(pc), 32'd4);
        chk("halted_stop", 32'(stop), 32'd1);
        cont = 1'b1;
        check_cycle();
        @(negedge clk);
        cont = 1'b0;
        chk("resume_stop", 32'(stop), 32'd0);
        chk("resume_addr", 32'(mem_addr), 32'd4);

        // CLR; BZ 20 taken
        run_cycles(6, 1'b0);
        chk("bz_taken_addr", 32'(mem_addr), 32'd20);
        // DEC; BZ 30 not taken
        run_cycles(6, 1'b0);
        chk("dec_ac", 32'(ac), 32'hFFF);
        chk("bz_not_taken_addr", 32'(mem_addr), 32'd22);
        // ADD overflow 0xFFF + 2
        run_cycles(5, 1'b0);
        chk("add_wrap_ac", 32'(ac), 32'h001);
        // LD 0xABC with cont asserted (must be ignored)
        run_cycles(5, 1'b1);
        chk("ld_ac", 32'(ac), 32'hABC);
        // ST to the LED address
        run_cycles(3, 1'b0);
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_addr", 32'(mem_addr), 32'o100);
        chk("leds_before", 32'(leds), 32'd0);
        run_cycles(1, 1'b0);
        chk("leds_after", 32'(leds), 32'hC);
        chk("ram_leds", 32'(ram[64]), 32'hABC);
        run_cycles(1, 1'b0);
        // BR 511, then CLR at 511 wraps to 0
        run_cycles(3, 1'b0);
        chk("br_addr", 32'(mem_addr), 32'd511);
        run_cycles(3, 1'b0);
        chk("wrap_addr", 32'(mem_addr), 32'd0);
        chk("wrap_ac", 32'(ac), 32'd0);

        // cont held high while halting: exactly one HALTED cycle
        run_cycles(18, 1'b1);
        chk("halt2_stop", 32'(stop), 32'd1);
        check_cycle();
        @(negedge clk);
        chk("halt2_released", 32'(stop), 32'd0);
        chk("halt2_addr", 32'(mem_addr), 32'd4);
        run_cycles(6, 1'b0);

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
